hybrid_out_stream: RTL and testbench

- Output stage directly downstream of the hybrid fixed-point filter top.
- Samples the filter's OUT_WIDTH offset-binary result once per downsampled period and buffers it in a small FIFO.
- Presents the samples on a ready/valid stream in the fast clk domain for the capture/readout logic.
- Optionally converts offset-binary to two's complement and tracks dropped samples.

---
 rtl/hybrid_out_stream_pkg.sv | 18 +
 rtl/hybrid_out_stream_sync_fifo.sv | 78 +++++++
 rtl/hybrid_out_stream.sv | 89 ++++++++
 tb/tb_hybrid_out_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_out_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hybrid_stream_p : shared sample type and format helpers              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hybrid_stream_p;

   localparam int c_OUT_WIDTH = 14;
   localparam int c_DEF_WIDTH = c_OUT_WIDTH;

   typedef logic [c_DEF_WIDTH-1:0] sample_t;

   function automatic sample_t ob_to_tc(input sample_t x);
      return {~x[c_DEF_WIDTH-1], x[c_DEF_WIDTH-2:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hybrid_out_stream_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered show-ahead head word   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo
   import hybrid_stream_p::*;
#(
   parameter int WIDTH = c_DEF_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int                c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]     c_FULL = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_AW:0]    r_count;
   logic [WIDTH-1:0] r_head;

   logic w_push_ok;
   logic w_pop_ok;
   logic w_bypass;
   logic w_mem_wr;
   logic w_mem_rd;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_FULL);
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);

   // The head register holds the oldest word; the array holds the rest.
   // A push goes straight to the head when it would otherwise be empty.
   assign w_bypass  = w_push_ok & (empty | ((r_count == (c_AW+1)'(1)) & w_pop_ok));
   assign w_mem_wr  = w_push_ok & ~w_bypass;
   assign w_mem_rd  = w_pop_ok & (r_count > (c_AW+1)'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         if (w_mem_wr) r_wptr <= r_wptr + 1'b1;
         if (w_mem_rd) begin
            r_head <= r_mem[r_rptr];
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_bypass) r_head <= wdata;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_wr) r_mem[r_wptr] <= wdata;
   end

   assign rdata = r_head;
   assign level = r_count;

endmodule
`default_nettype wire

// File: rtl/hybrid_out_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hybrid_out_stream : filter output sampler, FIFO and ready/valid port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hybrid_out_stream
   import hybrid_stream_p::*;
#(
   parameter int WIDTH     = c_DEF_WIDTH,
   parameter int DEPTH     = 8,
   parameter int TWOS_COMP = 1,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ds_tick,
   input  logic [WIDTH-1:0]         in_sample,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   input  logic                     ovf_clr
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [WIDTH-1:0] w_wdata;
   logic             w_sample;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic             w_drop;
   logic             r_overflow;
   logic [CNT_W-1:0] r_drop_cnt;

   generate
      if (TWOS_COMP != 0) begin : g_tc
         if (WIDTH == c_DEF_WIDTH) begin : g_pkg
            assign w_wdata = ob_to_tc(in_sample);
         end else begin : g_generic
            assign w_wdata = {~in_sample[WIDTH-1], in_sample[WIDTH-2:0]};
         end
      end else begin : g_pass
         assign w_wdata = in_sample;
      end
   endgenerate

   assign w_sample = ds_tick & in_valid;
   assign w_pop    = ~w_empty & out_ready;
   // A full FIFO still accepts a sample when the head leaves on the same edge.
   assign w_drop   = w_sample & w_full & ~w_pop;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_sample),
      .pop   (w_pop),
      .wdata (w_wdata),
      .rdata (out_data),
      .empty (w_empty),
      .full  (w_full),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != c_CNT_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign out_valid  = ~w_empty;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hybrid_out_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hybrid_out_stream : directed self-checking bench                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hybrid_out_stream;

   localparam int W = 14;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ds_tick = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         ovf_clr = 1'b0;
   logic [W-1:0] in_sample = '0;

   logic [W-1:0] out_data, out_data4;
   logic         out_valid, out_valid4;
   logic [3:0]   level, level4;
   logic         overflow, overflow4;
   logic [7:0]   drop_count;
   logic [3:0]   drop_count4;

   int           n_chk = 0;
   int           n_err = 0;
   logic [W-1:0] q[$];

   always #5 clk = ~clk;

   hybrid_out_stream #(.WIDTH(W), .DEPTH(D), .TWOS_COMP(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .ds_tick(ds_tick), .in_sample(in_sample), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .overflow(overflow), .drop_count(drop_count), .ovf_clr(ovf_clr));

   hybrid_out_stream #(.WIDTH(W), .DEPTH(D), .TWOS_COMP(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .ds_tick(ds_tick), .in_sample(in_sample), .in_valid(in_valid),
      .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready), .level(level4),
      .overflow(overflow4), .drop_count(drop_count4), .ovf_clr(ovf_clr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input logic [W-1:0] s);
      in_sample = s;
      ds_tick   = 1'b1;
      step();
      ds_tick   = 1'b0;
      step();
   endtask

   // Drains the stream, matching each head word against the queue.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      while (q.size() != 0) begin
         chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_data"}, {18'd0, out_data}, {18'd0, q[0]});
         void'(q.pop_front());
         step();
      end
      chk({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_level0"}, {28'd0, level}, 32'd0);
   endtask

   initial begin
      int   pushed;
      logic did_rst;
      logic tick;

      // Reset state
      step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {18'd0, out_data}, 32'd0);
      chk("rst_level", {28'd0, level}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_drop", {24'd0, drop_count}, 32'd0);
      rst = 1'b1;
      step();

      // Periodic ticks, midscale sample converts to zero
      in_valid = 1'b1; out_ready = 1'b1; in_sample = 14'h2000;
      for (int k = 0; k < 3; k++) begin
         ds_tick = 1'b1;
         step();
         ds_tick = 1'b0;
         chk("t1_valid", {31'd0, out_valid}, 32'd1);
         chk("t1_data", {18'd0, out_data}, 32'h0000);
         chk("t1_level1", {28'd0, level}, 32'd1);
         step();
         chk("t1_novalid", {31'd0, out_valid}, 32'd0);
         chk("t1_level0", {28'd0, level}, 32'd0);
         repeat (10) step();
      end

      // Ticks without in_valid are ignored
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) pulse_tick(14'h1234);
      chk("t2_valid", {31'd0, out_valid}, 32'd0);
      chk("t2_level", {28'd0, level}, 32'd0);
      chk("t2_ovf", {31'd0, overflow}, 32'd0);

      // Overfill: 10 samples into 8 entries
      in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 1; i <= 10; i++) pulse_tick(W'(i));
      for (int i = 1; i <= 8; i++) q.push_back(14'h2000 | W'(i));
      chk("t3_level", {28'd0, level}, 32'd8);
      chk("t3_ovf", {31'd0, overflow}, 32'd1);
      chk("t3_drop", {24'd0, drop_count}, 32'd2);
      drain("t3");
      out_ready = 1'b0;

      // Full FIFO, push and pop on the same edge
      for (int i = 0; i < 8; i++) begin
         pulse_tick(14'h0100 + W'(i));
         q.push_back(14'h2100 + W'(i));
      end
      chk("t4_full", {28'd0, level}, 32'd8);
      out_ready = 1'b1; ds_tick = 1'b1; in_sample = 14'h3FFF;
      chk("t4_head", {18'd0, out_data}, 32'h2100);
      void'(q.pop_front());
      q.push_back(14'h1FFF);
      step();
      ds_tick = 1'b0; out_ready = 1'b0;
      chk("t4_level", {28'd0, level}, 32'd8);
      chk("t4_drop", {24'd0, drop_count}, 32'd2);
      drain("t4");
      out_ready = 1'b0;
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("clr_ovf", {31'd0, overflow}, 32'd0);
      chk("clr_drop", {24'd0, drop_count}, 32'd0);

      // Random backpressure with a mid-burst reset
      pushed = 0; did_rst = 1'b0;
      for (int cyc = 0; cyc < 5000 && pushed < 200; cyc++) begin
         chk("bp_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         if (out_valid && q.size() != 0)
            chk("bp_data", {18'd0, out_data}, {18'd0, q[0]});
         chk("bp_level", {28'd0, level}, q.size());
         if (pushed >= 100 && !did_rst && q.size() > 0) begin
            did_rst = 1'b1;
            ds_tick = 1'b0; out_ready = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("bp_rst_valid", {31'd0, out_valid}, 32'd0);
            chk("bp_rst_level", {28'd0, level}, 32'd0);
            q.delete();
            step();
            rst = 1'b1;
            continue;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) void'(q.pop_front());
         tick = (cyc % 3 == 0) && (q.size() < D);
         ds_tick = tick;
         in_sample = W'($urandom);
         if (tick) begin
            q.push_back(in_sample ^ 14'h2000);
            pushed++;
         end
         step();
      end
      ds_tick = 1'b0;
      drain("bp");
      out_ready = 1'b0;

      // Saturation of the 4-bit counter, then clear racing a drop
      for (int i = 1; i <= 28; i++) pulse_tick(W'(i));
      chk("sat_level", {28'd0, level}, 32'd8);
      chk("sat_level4", {28'd0, level4}, 32'd8);
      chk("sat_head", {18'd0, out_data}, 32'h2001);
      chk("sat_head4", {18'd0, out_data4}, 32'h2001);
      chk("sat_valid4", {31'd0, out_valid4}, 32'd1);
      chk("sat_drop8", {24'd0, drop_count}, 32'd20);
      chk("sat_drop4", {28'd0, drop_count4}, 32'd15);
      chk("sat_ovf4", {31'd0, overflow4}, 32'd1);
      ds_tick = 1'b1; ovf_clr = 1'b1;
      step();
      ds_tick = 1'b0; ovf_clr = 1'b0;
      chk("race_ovf", {31'd0, overflow}, 32'd0);
      chk("race_drop", {24'd0, drop_count}, 32'd0);
      chk("race_ovf4", {31'd0, overflow4}, 32'd0);
      chk("race_drop4", {28'd0, drop_count4}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
